// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg
// Shared definitions for the ROM-download FIFO:
//   - dwnld_state_t : issue FSM states (IDLE, WRITE, GAP)
//   - MASK_LO/MASK_HI : SDRAM byte masks (1 = byte masked)
//   - BANK_UNUSED : bank start address that leaves a bank unmapped
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } dwnld_state_t;

  // Even bytes land in the low half, so the high half is masked
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

  localparam logic [24:0] BANK_UNUSED = 25'h1FF_FFFF;

endpackage

// File: rtl/jtframe_dwnld_fifo_mem.sv
// jtframe_dwnld_fifo_mem
// Circular-buffer FIFO with extra-MSB pointers, used to queue SDRAM writes.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset (pointers only)
//   push, din  : enqueue request and data; honoured when not full or when
//                a pop happens in the same cycle
//   pop, dout  : dequeue request; dout always shows the head entry
//   full, empty: occupancy flags
module jtframe_dwnld_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign dout = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo
// ROM-download buffer between the ioctl byte stream and the SDRAM
// programming port. Each ioctl byte becomes a byte-masked 16-bit write,
// queued so the SDRAM can stall, and issued with a prog_we/prog_rdy handshake.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   downloading                       : ROM transfer in progress
//   ioctl_addr/ioctl_dout/ioctl_wr    : incoming byte stream
//   prog_addr/data/mask/ba, prog_we   : registered SDRAM write request
//   prog_rdy                          : one-cycle completion from SDRAM
//   dwnld_busy                        : transfer or queued writes pending
//   overflow                          : sticky, a byte was dropped
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int          AW        = 22,
  parameter int          DEPTH     = 4,
  parameter logic [24:0] BA1_START = BANK_UNUSED,
  parameter logic [24:0] BA2_START = BANK_UNUSED,
  parameter logic [24:0] BA3_START = BANK_UNUSED
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic [1:0]    prog_ba,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          dwnld_busy,
  output logic          overflow
);

  localparam int EW = AW + 20;

  dwnld_state_t  state;
  logic [1:0]    push_ba;
  logic [24:0]   bank_start;
  logic [AW-1:0] word_addr;
  logic [1:0]    push_mask;
  logic [EW-1:0] push_entry, head;
  logic          fifo_full, fifo_empty, pop;
  logic          downloading_l, busy_cond, busy_pend;

  // Highest matching region wins; bank 0 starts at address zero
  always_comb begin
    push_ba    = 2'd0;
    bank_start = 25'd0;
    if (ioctl_addr >= BA3_START) begin
      push_ba    = 2'd3;
      bank_start = BA3_START;
    end else if (ioctl_addr >= BA2_START) begin
      push_ba    = 2'd2;
      bank_start = BA2_START;
    end else if (ioctl_addr >= BA1_START) begin
      push_ba    = 2'd1;
      bank_start = BA1_START;
    end
  end

  assign word_addr  = AW'((ioctl_addr - bank_start) >> 1);
  assign push_mask  = ioctl_addr[0] ? MASK_HI : MASK_LO;
  assign push_entry = {push_ba, push_mask, ioctl_dout, ioctl_dout, word_addr};

  // The head leaves the queue only when the controller acknowledges it
  assign pop = (state == WRITE) && prog_rdy;

  jtframe_dwnld_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (ioctl_wr),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM: the head is copied into the output registers and held until
  // prog_rdy, then a one-cycle gap keeps prog_we low between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= 16'd0;
      prog_mask <= 2'b11;
      prog_ba   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            prog_addr <= head[AW-1:0];
            prog_data <= head[AW+15:AW];
            prog_mask <= head[AW+17:AW+16];
            prog_ba   <= head[AW+19:AW+18];
            prog_we   <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (prog_rdy) begin
            prog_we <= 1'b0;
            state   <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_cond = downloading || !fifo_empty || (state != IDLE);

  // busy_pend stretches the falling edge of dwnld_busy by one extra cycle
  // while the rising edge still follows downloading after a single cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      downloading_l <= 1'b0;
      busy_pend     <= 1'b0;
      dwnld_busy    <= 1'b0;
    end else begin
      downloading_l <= downloading;
      busy_pend     <= busy_cond;
      dwnld_busy    <= busy_cond || busy_pend;
      if (ioctl_wr && fifo_full && !pop)
        overflow <= 1'b1;
      else if (downloading && !downloading_l)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_fifo.sv
// tb_jtframe_dwnld_fifo
// Self-checking bench for jtframe_dwnld_fifo. Expected SDRAM writes are
// computed from each ioctl byte and queued; a prog_rdy responder compares
// the DUT outputs against the queue head whenever it acknowledges a write.
module tb_jtframe_dwnld_fifo;

  localparam int          AW    = 22;
  localparam logic [24:0] BA1   = 25'h100000;
  localparam logic [24:0] UNUSD = 25'h1FF_FFFF;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
    logic [1:0]    ba;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wr;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic [1:0]    prog_ba;
  logic          prog_we;
  logic          prog_rdy = 1'b0;
  logic          dwnld_busy;
  logic          overflow;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rdy_enable = 1'b0;
  int   rdy_delay = 0;
  int   rdy_cnt = 0;

  jtframe_dwnld_fifo #(
    .AW        (AW),
    .DEPTH     (4),
    .BA1_START (BA1),
    .BA2_START (UNUSD),
    .BA3_START (UNUSD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Hard stop in case some wait never completes
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference address/bank/mask mapping for one ioctl byte
  function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
    exp_t        e;
    logic [24:0] start;
    if (a >= UNUSD) begin
      e.ba = 2'd3; start = UNUSD;
    end else if (a >= BA1) begin
      e.ba = 2'd1; start = BA1;
    end else begin
      e.ba = 2'd0; start = 25'd0;
    end
    e.addr = AW'((a - start) >> 1);
    e.data = {d, d};
    e.mask = a[0] ? 2'b01 : 2'b10;
    return e;
  endfunction

  // Drive one ioctl byte for a single cycle; accepted bytes join the scoreboard
  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input bit accept);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (accept) sb.push_back(model(a, d));
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // SDRAM controller model: after rdy_delay cycles of prog_we it pulses
  // prog_rdy for one cycle and checks the write against the scoreboard head
  always @(posedge clk) begin
    #2;
    if (rst) begin
      prog_rdy = 1'b0;
      rdy_cnt  = 0;
    end else if (prog_rdy) begin
      prog_rdy = 1'b0;
    end else if (rdy_enable && prog_we) begin
      if (rdy_cnt >= rdy_delay) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_write", 64'(prog_we), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_addr", 64'(prog_addr), 64'(e.addr));
          checkOutput("sb_data", 64'(prog_data), 64'(e.data));
          checkOutput("sb_mask", 64'(prog_mask), 64'(e.mask));
          checkOutput("sb_ba",   64'(prog_ba),   64'(e.ba));
        end
        prog_rdy = 1'b1;
        rdy_cnt  = 0;
      end else begin
        rdy_cnt++;
      end
    end
  end

  // Directed sequence
  initial begin
    int we_seen;
    int waited;
    rst         = 1'b1;
    downloading = 1'b0;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'd0;
    ioctl_wr    = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_we",       64'(prog_we),    64'd0);
    checkOutput("rst_addr",     64'(prog_addr),  64'd0);
    checkOutput("rst_data",     64'(prog_data),  64'd0);
    checkOutput("rst_mask",     64'(prog_mask),  64'd3);
    checkOutput("rst_ba",       64'(prog_ba),    64'd0);
    checkOutput("rst_busy",     64'(dwnld_busy), 64'd0);
    checkOutput("rst_overflow", 64'(overflow),   64'd0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("busy_idle", 64'(dwnld_busy), 64'd0);
    downloading = 1'b1;
    @(negedge clk);
    checkOutput("busy_rise", 64'(dwnld_busy), 64'd1);

    $display("[TB] single write latency");
    rdy_enable = 1'b1;
    rdy_delay  = 2;
    applyStimulus(25'h000004, 8'hA5, 1'b1);
    checkOutput("lat_we_n1", 64'(prog_we), 64'd0);
    @(negedge clk);
    checkOutput("lat_we_n2", 64'(prog_we),   64'd1);
    checkOutput("lat_addr",  64'(prog_addr), 64'd2);
    checkOutput("lat_data",  64'(prog_data), 64'hA5A5);
    checkOutput("lat_mask",  64'(prog_mask), 64'd2);
    checkOutput("lat_ba",    64'(prog_ba),   64'd0);
    @(negedge clk);
    checkOutput("lat_we_n3", 64'(prog_we), 64'd1);
    @(negedge clk);
    checkOutput("lat_we_n4", 64'(prog_we), 64'd1);
    @(negedge clk);
    checkOutput("lat_we_n5", 64'(prog_we), 64'd0);
    waitDrain();

    $display("[TB] bank 1 odd byte");
    rdy_delay = 0;
    applyStimulus(25'h100003, 8'h3C, 1'b1);
    @(negedge clk);
    checkOutput("ba1_ba",   64'(prog_ba),   64'd1);
    checkOutput("ba1_addr", 64'(prog_addr), 64'd1);
    checkOutput("ba1_mask", 64'(prog_mask), 64'd1);
    checkOutput("ba1_data", 64'(prog_data), 64'h3C3C);
    waitDrain();
    repeat (3) @(negedge clk);

    $display("[TB] overflow");
    rdy_enable = 1'b0;
    applyStimulus(25'h000010, 8'h11, 1'b1);
    applyStimulus(25'h000011, 8'h22, 1'b1);
    applyStimulus(25'h200001, 8'h33, 1'b1);
    applyStimulus(25'h000020, 8'h44, 1'b1);
    checkOutput("ovf_before", 64'(overflow), 64'd0);
    applyStimulus(25'h000030, 8'hEE, 1'b0);
    checkOutput("ovf_set", 64'(overflow), 64'd1);
    rdy_enable = 1'b1;
    waitDrain();
    repeat (4) @(negedge clk);
    checkOutput("ovf_sticky", 64'(overflow), 64'd1);
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
    checkOutput("ovf_clear", 64'(overflow), 64'd0);

    $display("[TB] push and pop while full");
    rdy_enable = 1'b0;
    applyStimulus(25'h000040, 8'h51, 1'b1);
    applyStimulus(25'h000041, 8'h52, 1'b1);
    applyStimulus(25'h000042, 8'h53, 1'b1);
    applyStimulus(25'h000043, 8'h54, 1'b1);
    rdy_enable = 1'b1;
    rdy_delay  = 0;
    applyStimulus(25'h000044, 8'h55, 1'b1);
    checkOutput("full_pushpop_ovf", 64'(overflow), 64'd0);
    waitDrain();
    repeat (4) @(negedge clk);

    $display("[TB] busy after downloading falls");
    rdy_enable = 1'b0;
    applyStimulus(25'h000050, 8'h61, 1'b1);
    applyStimulus(25'h000051, 8'h62, 1'b1);
    applyStimulus(25'h000052, 8'h63, 1'b1);
    @(negedge clk);
    downloading = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("busy_hold", 64'(dwnld_busy), 64'd1);
    rdy_enable = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("busy_drain", 64'(sb.size()), 64'd0);
    checkOutput("busy_r0", 64'(dwnld_busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_r1", 64'(dwnld_busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_r2", 64'(dwnld_busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_r3", 64'(dwnld_busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_r4", 64'(dwnld_busy), 64'd0);

    $display("[TB] reset during write");
    downloading = 1'b1;
    rdy_enable  = 1'b0;
    applyStimulus(25'h000060, 8'h71, 1'b1);
    applyStimulus(25'h000061, 8'h72, 1'b1);
    @(negedge clk);
    checkOutput("mid_we", 64'(prog_we), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we",   64'(prog_we),    64'd0);
    checkOutput("mid_rst_addr", 64'(prog_addr),  64'd0);
    checkOutput("mid_rst_data", 64'(prog_data),  64'd0);
    checkOutput("mid_rst_mask", 64'(prog_mask),  64'd3);
    checkOutput("mid_rst_ba",   64'(prog_ba),    64'd0);
    checkOutput("mid_rst_busy", 64'(dwnld_busy), 64'd0);
    sb.delete();
    @(negedge clk);
    rst        = 1'b0;
    rdy_enable = 1'b1;
    we_seen    = 0;
    repeat (10) begin
      @(negedge clk);
      if (prog_we) we_seen++;
    end
    checkOutput("no_write_after_rst", 64'(we_seen), 64'd0);
    applyStimulus(25'h000071, 8'h81, 1'b1);
    waitDrain();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
